// File: rtl/atd_block.sv
// atd_block: serial-to-parallel receiver for the two-wire ATD link.
// ATD_clk and ATD_data come from outside the clk domain and are synchronised
// before use. Bits are shifted in MSB-first on each detected ATD_clk rise.
// Every DATA_WIDTH bits the completed word is presented on ATD_parallel with
// a ready/taken handshake.
module atd_block #(
    parameter int DATA_WIDTH   = 128,
    parameter int NUM_CNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  ATD_data,
    input  logic                  ATD_clk,
    input  logic                  data_taken,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] ATD_parallel
);

    localparam logic [NUM_CNT_BITS-1:0] LAST_BIT = NUM_CNT_BITS'(DATA_WIDTH - 1);

    logic                    clk_s1;
    logic                    clk_s2;
    logic                    clk_s3;
    logic                    data_s1;
    logic                    data_s2;
    logic                    rise;
    logic                    frame_done;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   next_word;
    logic [NUM_CNT_BITS-1:0] bit_cnt;

    // Two-flop synchronisers for both ATD wires, plus a history flop on the clock
    // so a rise can be detected. The history flop resets low on purpose: an
    // ATD_clk held high through reset release shows up as one rise.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            clk_s3  <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            clk_s1  <= ATD_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ATD_data;
            data_s2 <= data_s1;
        end
    end

    assign rise       = clk_s2 & ~clk_s3;
    assign frame_done = rise && (bit_cnt == LAST_BIT);
    assign next_word  = {shreg[DATA_WIDTH-2:0], data_s2};

    // The shift register takes one bit per rise. It keeps running while a
    // previous word waits to be taken.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            shreg <= '0;
        end else if (rise) begin
            shreg <= next_word;
        end
    end

    // Count bits within the frame. The count wraps to zero on the last bit, so
    // frame boundaries come only from the count and never from idle gaps.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            bit_cnt <= '0;
        end else if (frame_done) begin
            bit_cnt <= '0;
        end else if (rise) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Output word and handshake. A completion takes priority over data_taken.
    // An unconsumed word is silently overwritten by the next one.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            ATD_parallel <= '0;
            data_ready   <= 1'b0;
        end else if (frame_done) begin
            ATD_parallel <= next_word;
            data_ready   <= 1'b1;
        end else if (data_taken) begin
            data_ready   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_atd_block.sv
// Testbench for atd_block: directed ATD frames. Expected words are queued when
// a frame is sent, and a monitor pops one each time the DUT presents a new word.
module tb_atd_block;

    logic         tb_clk = 1'b0;
    logic         n_rst;
    logic         ATD_data;
    logic         ATD_clk;
    logic         data_taken;
    logic         data_ready;
    logic [127:0] ATD_parallel;

    int           checks   = 0;
    int           failures = 0;
    logic [127:0] exp_q[$];
    bit           mon_en   = 1'b0;
    logic         rdy_prev = 1'b0;
    logic [127:0] par_prev = '0;

    localparam logic [127:0] ALT  = {32{4'hA}};
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] HEX  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] BEEF = 128'hDEADBEEFCAFEF00D5A5A5A5A12345678;

    atd_block #(.DATA_WIDTH(128), .NUM_CNT_BITS(8)) dut (
        .clk          (tb_clk),
        .n_rst        (n_rst),
        .ATD_data     (ATD_data),
        .ATD_clk      (ATD_clk),
        .data_taken   (data_taken),
        .data_ready   (data_ready),
        .ATD_parallel (ATD_parallel)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance n clock cycles, leaving inputs settled just after the rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge tb_clk);
            #1;
        end
    endtask

    // Send raw bits without a full frame (no completion expected).
    task automatic send_bits(input int n, input logic val, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            ATD_data = val;
            ATD_clk  = 1'b0;
            tick(lo);
            ATD_clk  = 1'b1;
            tick(hi);
        end
    endtask

    // Send one full frame MSB-first. The last bit is tracked edge by edge:
    // after the 2nd clk edge the word is not yet complete, and after the 3rd it is.
    task automatic send_frame(input logic [127:0] f, input int hi, input int lo,
                              input bit expect_idle, input bit take_at_end);
        exp_q.push_back(f);
        for (int i = 0; i < 128; i++) begin
            ATD_data = f[127-i];
            ATD_clk  = 1'b0;
            tick(lo);
            ATD_clk  = 1'b1;
            if (i < 127) begin
                tick(hi);
            end else begin
                @(posedge tb_clk);
                @(posedge tb_clk);
                @(negedge tb_clk);
                if (expect_idle) chk("ready_before_last_capture", data_ready, 128'd0);
                if (take_at_end) data_taken = 1'b1;
                @(posedge tb_clk);
                @(negedge tb_clk);
                data_taken = 1'b0;
                chk("ready_at_completion", data_ready, 128'd1);
                tick(hi - 3);
            end
        end
    endtask

    // Monitor: a new word is presented when data_ready rises, or when the word
    // changes while data_ready is already high (overrun).
    always @(negedge tb_clk) begin
        if (mon_en && data_ready && (!rdy_prev || ATD_parallel !== par_prev)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %h expected none", ATD_parallel);
            end else begin
                chk("word", ATD_parallel, exp_q.pop_front());
            end
        end
        rdy_prev <= data_ready;
        par_prev <= ATD_parallel;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst      = 1'b1;
        ATD_clk    = 1'b0;
        ATD_data   = 1'b0;
        data_taken = 1'b0;

        // Reset with random ATD activity
        for (int i = 0; i < 2; i++) begin
            ATD_clk  = 1'($urandom_range(0, 1));
            ATD_data = 1'($urandom_range(0, 1));
            @(posedge tb_clk);
            @(negedge tb_clk);
            mon_en = 1'b1;
            chk("reset_ready", data_ready, 128'd0);
            chk("reset_parallel", ATD_parallel, 128'd0);
        end
        n_rst   = 1'b0;
        ATD_clk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_clk);
            chk("post_reset_ready", data_ready, 128'd0);
            chk("post_reset_parallel", ATD_parallel, 128'd0);
        end
        tick(1);

        // Alternating frame, then a one-cycle data_taken
        send_frame(ALT, 4, 4, 1'b1, 1'b0);
        data_taken = 1'b1;
        tick(1);
        data_taken = 1'b0;
        @(negedge tb_clk);
        chk("taken_ready_low", data_ready, 128'd0);
        chk("taken_parallel_held", ATD_parallel, ALT);
        tick(1);

        // data_taken while idle does nothing
        data_taken = 1'b1;
        tick(2);
        data_taken = 1'b0;
        @(negedge tb_clk);
        chk("idle_taken_ready", data_ready, 128'd0);
        tick(1);

        // 127 bits, reset, then a full all-ones frame
        send_bits(127, 1'b0, 4, 4);
        ATD_clk = 1'b0;
        tick(3);
        n_rst = 1'b1;
        tick(2);
        n_rst = 1'b0;
        @(negedge tb_clk);
        chk("midframe_reset_parallel", ATD_parallel, 128'd0);
        chk("midframe_reset_ready", data_ready, 128'd0);
        tick(1);
        send_frame(ONES, 4, 4, 1'b1, 1'b0);

        // Overrun with zeros, then data_taken coinciding with a completion
        send_frame(128'd0, 4, 4, 1'b0, 1'b0);
        chk("overrun_parallel", ATD_parallel, 128'd0);
        send_frame(BEEF, 4, 4, 1'b0, 1'b1);
        chk("taken_vs_done_parallel", ATD_parallel, BEEF);

        // Consume, then slow frame
        data_taken = 1'b1;
        tick(1);
        data_taken = 1'b0;
        send_frame(HEX, 20, 20, 1'b1, 1'b0);
        data_taken = 1'b1;
        tick(1);
        data_taken = 1'b0;
        @(negedge tb_clk);
        chk("final_ready_low", data_ready, 128'd0);
        chk("final_parallel", ATD_parallel, HEX);
        tick(20);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
